// File: rtl/ex_mem_if.sv
// EX/MEM stage bundle: EX-stage inputs, hazard controls, dcache port and MEM-stage outputs.
// The slave modport is the latch itself. The master modport is whoever drives it.
interface ex_mem_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
);
  logic              exe_valid;
  logic              exe_regWr;
  logic [REG_W-1:0]  exe_regDst;
  logic [WORD_W-1:0] exe_aluOut;
  logic [WORD_W-1:0] exe_storeData;
  logic              exe_dREN;
  logic              exe_dWEN;
  logic              exe_halt;
  logic              flush;
  logic              hold;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              mem_stall;
  logic              mem_regWr;
  logic [REG_W-1:0]  mem_regDst;
  logic [WORD_W-1:0] mem_result;
  logic              mem_ready;
  logic              mem_halt;

  modport slave (
    input  exe_valid, exe_regWr, exe_regDst, exe_aluOut, exe_storeData,
           exe_dREN, exe_dWEN, exe_halt, flush, hold, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, mem_regWr,
           mem_regDst, mem_result, mem_ready, mem_halt
  );

  modport master (
    output exe_valid, exe_regWr, exe_regDst, exe_aluOut, exe_storeData,
           exe_dREN, exe_dWEN, exe_halt, flush, hold, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, mem_regWr,
           mem_regDst, mem_result, mem_ready, mem_halt
  );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with a two-state dcache request sequencer.
// A load or store holds the pipe in WAIT until dhit. A captured HALT freezes the register until reset.
module ex_mem_latch #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic    clk,
  input  logic    rst,
  ex_mem_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_q;
  logic              valid_q;
  logic              regwr_q;
  logic [REG_W-1:0]  regdst_q;
  logic [WORD_W-1:0] aluout_q;
  logic [WORD_W-1:0] store_q;
  logic              dren_q;
  logic              dwen_q;
  logic              halt_q;

  logic stall;
  logic ld;
  logic exe_mem_op;

  assign stall      = (state_q == WAIT) && !bus.dhit;
  assign ld         = !stall && !bus.hold && !halt_q;
  assign exe_mem_op = bus.exe_valid && (bus.exe_dREN || bus.exe_dWEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      regwr_q  <= 1'b0;
      regdst_q <= '0;
      aluout_q <= '0;
      store_q  <= '0;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else if (!stall && !halt_q && bus.flush) begin
      // Only takes effect once any outstanding request has completed.
      state_q <= IDLE;
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
    end else if (ld) begin
      state_q  <= exe_mem_op ? WAIT : IDLE;
      valid_q  <= bus.exe_valid;
      regwr_q  <= bus.exe_regWr;
      regdst_q <= bus.exe_regDst;
      aluout_q <= bus.exe_aluOut;
      store_q  <= bus.exe_storeData;
      dren_q   <= bus.exe_dREN;
      dwen_q   <= bus.exe_dWEN;
      halt_q   <= bus.exe_valid && bus.exe_halt;
    end else if (!stall) begin
      // The request was satisfied but the contents are held: the request must not be issued again.
      state_q <= IDLE;
    end
  end

  assign bus.dmemREN    = (state_q == WAIT) && dren_q;
  assign bus.dmemWEN    = (state_q == WAIT) && dwen_q;
  assign bus.dmemaddr   = aluout_q;
  assign bus.dmemstore  = store_q;
  assign bus.mem_stall  = stall;
  assign bus.mem_regWr  = valid_q && regwr_q;
  assign bus.mem_regDst = regdst_q;
  assign bus.mem_result = ((state_q == WAIT) && dren_q && bus.dhit) ? bus.dmemload : aluout_q;
  assign bus.mem_ready  = valid_q && ((state_q == IDLE) || bus.dhit);
  assign bus.mem_halt   = halt_q;
endmodule
